input_event_scheduler: RTL and testbench
========================================

# input_event_scheduler

Front-end for the eight game-pad buttons (left, right, down, up, select, start, a, b). It synchronises and debounces each button and latches rising edges as pending events. A round-robin arbiter then shares the single 4-bit interrupt channel to the CPU among the pending events, using a valid/ack handshake. The block sits between the pad pins and the CPU interrupt input and replaces direct combinational encoding of button levels.

## Interface
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change (≥1)
- REPEAT_DELAY, 16: held cycles after an accepted press before the first auto-repeat (autorepeat build only)
- REPEAT_PERIOD, 8: cycles between subsequent auto-repeats (autorepeat build only)
- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- left, right, down, up, select, start, a, b  input  1 each  raw asynchronous button levels, active-high
- irq_valid  output  1  an event code is presented
- irq_code  output  4  event code: left=1, right=2, down=3, up=4, select=5, start=6, a=7, b=8; 0 when irq_valid=0
- irq_ack  input  1  CPU consumes the presented event; ignored when irq_valid=0
- btn_state  output  8  debounced levels, bit0=left … bit7=b
- irq_overrun  output  1  one-cycle pulse when a press hits an already-pending bit

## Operation
- Per button: 2-flop synchroniser feeding a debounce counter. Counter resets whenever the synchronised level equals the stable level. When the levels have differed for DEBOUNCE_CYCLES consecutive edges, the stable level flips and the counter clears.
- A stable 0→1 transition (press) sets pending[i]. A 1→0 transition (release) generates no event.
- pending[i] already set at a press: the bit stays set and irq_overrun pulses.
- Arbiter: when irq_valid=0, or when irq_valid=1 and irq_ack=1, select the next pending index by round-robin.
  - Search order starts at last_grant+1 (mod 8).
  - The index being acked in the current cycle is excluded from the search.
  - The winner is registered into irq_code/irq_valid, and last_grant is updated.
- irq_code and irq_valid stay stable until acked.
- On ack, pending[code-1] clears on the same edge. If that button presses in the same cycle, set wins: the bit stays pending and irq_overrun does not pulse.
- No pending bits and no presentation: irq_valid=0, irq_code=0.
- Reset values: all pending=0, stable levels=0, counters=0, synchronisers=0, last_grant=7 (first search starts at left), irq_valid=0, irq_code=0, btn_state=0, irq_overrun=0.
- Reset mid-operation discards presented and pending events. Buttons held through reset re-register as presses after synchroniser plus debounce latency.

## Timing
- Idle press latency: raw high sampled at edge k → btn_state bit and pending set at edge k+1+DEBOUNCE_CYCLES → irq_valid=1 at edge k+2+DEBOUNCE_CYCLES.
- Glitch shorter than DEBOUNCE_CYCLES synchronised samples: no btn_state change, no event.
- Back-to-back: irq_ack=1 at edge n with another event pending → new code valid at edge n+1, with no idle cycle.
- Single pending event acked at edge n → irq_valid=0 at edge n+1.
- irq_overrun is high for exactly the one cycle following the offending edge.

## Configuration
- INPUT_AUTOREPEAT_EN defined:
  - left, right and down each own a repeat counter that starts on accepted press.
  - After REPEAT_DELAY cycles held, then every REPEAT_PERIOD cycles, the block re-sets pending (with overrun rules as for a press).
  - Release or reset clears the counter.
- Undefined: no repeat logic is present; each press yields exactly one event; the REPEAT_* parameters are unused.

## Structure
- Package tetris_input_pkg holds:
  - NUM_BUTTONS=8
  - the button index enum (BTN_LEFT=0 … BTN_B=7)
  - IRQ_CODE_W=4
  - the code constants (IRQ_NONE=0, IRQ_LEFT=1 … IRQ_B=8)
- Sub-module input_debouncer (synchroniser plus counter, parameter DEBOUNCE_CYCLES, ports clk, rst, raw, stable, rise) is instantiated once per button.
- The arbiter, pending register and repeat logic live in the top module.

## Test plan
- After reset, all inputs 0 → irq_valid=0, irq_code=0, btn_state=0 throughout 20 cycles.
- left high from edge 2 → btn_state=8'h01 and irq_valid=1, irq_code=1 at edge 8 (DEBOUNCE_CYCLES=4). Ack → irq_valid=0 next edge.
- left and a rise in the same cycle, irq_ack held high → codes 1 then 7 on consecutive cycles, then irq_valid=0.
- down pulses high for 2 cycles → no btn_state change, no event.
- Second press of b while code 8 is unacked → irq_overrun pulses once, and only one code-8 event is delivered. Press of b in the same cycle as its ack → a second code 8 is presented next cycle, with no overrun.
- With INPUT_AUTOREPEAT_EN, right held 40 cycles, ack immediately → code 2 events at press+0, +16, +24, +32 relative to first valid. Without the macro → exactly one event.

Source files
------------

// File: rtl/tetris_input_pkg.sv
// Shared constants and types for the game-pad input front-end.
package tetris_input_pkg;

    localparam int unsigned NUM_BUTTONS = 8;
    localparam int unsigned BTN_IDX_W   = 3;
    localparam int unsigned IRQ_CODE_W  = 4;

    typedef enum logic [BTN_IDX_W-1:0] {
        BTN_LEFT   = 3'd0,
        BTN_RIGHT  = 3'd1,
        BTN_DOWN   = 3'd2,
        BTN_UP     = 3'd3,
        BTN_SELECT = 3'd4,
        BTN_START  = 3'd5,
        BTN_A      = 3'd6,
        BTN_B      = 3'd7
    } btn_idx_e;

    localparam logic [IRQ_CODE_W-1:0] IRQ_NONE   = 4'd0;
    localparam logic [IRQ_CODE_W-1:0] IRQ_LEFT   = 4'd1;
    localparam logic [IRQ_CODE_W-1:0] IRQ_RIGHT  = 4'd2;
    localparam logic [IRQ_CODE_W-1:0] IRQ_DOWN   = 4'd3;
    localparam logic [IRQ_CODE_W-1:0] IRQ_UP     = 4'd4;
    localparam logic [IRQ_CODE_W-1:0] IRQ_SELECT = 4'd5;
    localparam logic [IRQ_CODE_W-1:0] IRQ_START  = 4'd6;
    localparam logic [IRQ_CODE_W-1:0] IRQ_A      = 4'd7;
    localparam logic [IRQ_CODE_W-1:0] IRQ_B      = 4'd8;

    // Event codes are the button index plus one; zero means "nothing".
    function automatic logic [IRQ_CODE_W-1:0] idx_to_code(input logic [BTN_IDX_W-1:0] idx);
        return IRQ_CODE_W'(idx) + IRQ_CODE_W'(1);
    endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser plus debounce counter for one raw button level.
// rise is combinational and coincides with the edge on which stable goes 0->1.
module input_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync1_q, sync2_q;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flip;

    // Count consecutive disagreeing samples; flip the stable level on the last one.
    always_comb begin
        flip     = (sync2_q != stable_q) && (cnt_q == CntLast);
        stable_d = stable_q ^ flip;
        if ((sync2_q == stable_q) || flip) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    // Synchroniser, stable level and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = flip & ~stable_q;

endmodule

// File: rtl/input_event_scheduler.sv
// Game-pad front-end: debounces eight buttons, latches presses as pending events and
// hands them to the CPU one at a time through a round-robin valid/ack channel.
// Optional build macro INPUT_AUTOREPEAT_EN adds auto-repeat on left/right/down.
module input_event_scheduler
    import tetris_input_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 16,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   left,
    input  logic                   right,
    input  logic                   down,
    input  logic                   up,
    input  logic                   select,
    input  logic                   start,
    input  logic                   a,
    input  logic                   b,
    input  logic                   irq_ack,
    output logic                   irq_valid,
    output logic [IRQ_CODE_W-1:0]  irq_code,
    output logic [NUM_BUTTONS-1:0] btn_state,
    output logic                   irq_overrun
);

    logic [NUM_BUTTONS-1:0] raw_vec, stable_vec, rise_vec, rep_fire, set_vec;
    logic [NUM_BUTTONS-1:0] pending_q, pending_d, clr_vec, cand;
    logic [BTN_IDX_W-1:0]   last_grant_q, last_grant_d, ack_idx, win_idx, idx;
    logic [IRQ_CODE_W-1:0]  irq_code_q, irq_code_d;
    logic                   irq_valid_q, irq_valid_d, overrun_q, overrun_d;
    logic                   ack_fire, found;

    assign raw_vec = {b, a, start, select, up, down, right, left};

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_deb
        input_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk   (clk),
            .rst   (rst),
            .raw   (raw_vec[gi]),
            .stable(stable_vec[gi]),
            .rise  (rise_vec[gi])
        );
    end

`ifdef INPUT_AUTOREPEAT_EN
    localparam int unsigned NumRep = 32'(BTN_DOWN) + 1;
    localparam int unsigned RepMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RepW   = (RepMax > 1) ? $clog2(RepMax) : 1;

    logic [RepW-1:0] rep_cnt_q [NumRep];
    logic [RepW-1:0] rep_cnt_d [NumRep];

    // Down-counters: loaded on press, fire at zero and reload with the period.
    always_comb begin
        rep_fire = '0;
        for (int unsigned i = 0; i < NumRep; i++) begin
            rep_cnt_d[i] = rep_cnt_q[i];
            if (rise_vec[i]) begin
                rep_cnt_d[i] = RepW'(REPEAT_DELAY - 1);
            end else if (stable_vec[i]) begin
                if (rep_cnt_q[i] == '0) begin
                    rep_fire[i]  = 1'b1;
                    rep_cnt_d[i] = RepW'(REPEAT_PERIOD - 1);
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] - RepW'(1);
                end
            end else begin
                rep_cnt_d[i] = '0;
            end
        end
    end

    // Repeat counter registers.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NumRep; i++) begin
            if (rst) begin
                rep_cnt_q[i] <= '0;
            end else begin
                rep_cnt_q[i] <= rep_cnt_d[i];
            end
        end
    end
`else
    assign rep_fire = '0;
`endif

    // Pending set/clear, overrun detection and round-robin selection.
    always_comb begin
        ack_fire     = irq_valid_q & irq_ack;
        ack_idx      = irq_code_q[BTN_IDX_W-1:0] - BTN_IDX_W'(1);
        clr_vec      = ack_fire ? (NUM_BUTTONS'(1) << ack_idx) : '0;
        set_vec      = rise_vec | rep_fire;
        // A set landing on the bit being acked is a fresh event, not an overrun.
        overrun_d    = |(set_vec & pending_q & ~clr_vec);
        pending_d    = (pending_q & ~clr_vec) | set_vec;
        cand         = pending_q & ~clr_vec;
        found        = 1'b0;
        win_idx      = last_grant_q;
        idx          = '0;
        for (int unsigned off = 1; off <= NUM_BUTTONS; off++) begin
            idx = last_grant_q + BTN_IDX_W'(off);
            if (!found && cand[idx]) begin
                found   = 1'b1;
                win_idx = idx;
            end
        end
        irq_valid_d  = irq_valid_q;
        irq_code_d   = irq_code_q;
        last_grant_d = last_grant_q;
        if (!irq_valid_q || ack_fire) begin
            if (found) begin
                irq_valid_d  = 1'b1;
                irq_code_d   = idx_to_code(win_idx);
                last_grant_d = win_idx;
            end else begin
                irq_valid_d  = 1'b0;
                irq_code_d   = IRQ_NONE;
            end
        end
    end

    // Arbiter and pending state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q    <= '0;
            last_grant_q <= BTN_B;
            irq_valid_q  <= 1'b0;
            irq_code_q   <= IRQ_NONE;
            overrun_q    <= 1'b0;
        end else begin
            pending_q    <= pending_d;
            last_grant_q <= last_grant_d;
            irq_valid_q  <= irq_valid_d;
            irq_code_q   <= irq_code_d;
            overrun_q    <= overrun_d;
        end
    end

    assign irq_valid   = irq_valid_q;
    assign irq_code    = irq_code_q;
    assign btn_state   = stable_vec;
    assign irq_overrun = overrun_q;

endmodule

// File: tb/tb_input_event_scheduler.sv
// Bench for input_event_scheduler: directed table, corner-case sequences and a
// randomized run against a window-based behavioural model.
module tb_input_event_scheduler;

    localparam int DEB    = 4;
    localparam int DELAY  = 16;
    localparam int PERIOD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_left = 0, btn_right = 0, btn_down = 0, btn_up = 0;
    logic       btn_select = 0, btn_start = 0, btn_a = 0, btn_b = 0;
    logic       irq_ack = 1'b0;
    logic       irq_valid, irq_overrun;
    logic [3:0] irq_code;
    logic [7:0] btn_state;

    int n_checks = 0;
    int n_fail   = 0;

    input_event_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left       (btn_left),
        .right      (btn_right),
        .down       (btn_down),
        .up         (btn_up),
        .select     (btn_select),
        .start      (btn_start),
        .a          (btn_a),
        .b          (btn_b),
        .irq_ack    (irq_ack),
        .irq_valid  (irq_valid),
        .irq_code   (irq_code),
        .btn_state  (btn_state),
        .irq_overrun(irq_overrun)
    );

    always #5 clk = ~clk;

    // Behavioural model state; edge 0 is the last reset edge.
    int         m_e;
    logic [7:0] m_hist[$];
    logic [7:0] m_stable, m_pend;
    int         m_last_flip[8];
    int         m_press_edge[8];
    logic       m_valid, m_ovr;
    logic [3:0] m_code;
    int         m_lg;

    task automatic model_reset();
        m_e = 0;
        m_hist.delete();
        m_hist.push_back(8'h00);
        m_stable = '0;
        m_pend   = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_code   = 4'd0;
        m_lg     = 7;
        for (int i = 0; i < 8; i++) begin
            m_last_flip[i]  = 0;
            m_press_edge[i] = 0;
        end
    endtask

    // A level is accepted once the last DEB synchronised samples (raw two edges
    // earlier) all differ from the stable level and lie after the previous flip.
    task automatic model_step(input logic [7:0] r, input logic ack, input logic rs);
        logic [7:0] press, rep, set, h;
        logic       ackf, all_diff, s;
        int         ai, win, idx, n;
        bit         found;
        if (rs) begin
            model_reset();
            return;
        end
        m_e++;
        m_hist.push_back(r);
        press = '0;
        rep   = '0;
`ifdef INPUT_AUTOREPEAT_EN
        for (int i = 0; i < 3; i++) begin
            if (m_stable[i]) begin
                n = m_e - m_press_edge[i];
                if (n == DELAY || (n > DELAY && (n - DELAY) % PERIOD == 0)) rep[i] = 1'b1;
            end
        end
`endif
        for (int i = 0; i < 8; i++) begin
            if (m_e - m_last_flip[i] >= DEB) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DEB + 1; j++) begin
                    if (m_e - j >= 0) begin
                        h = m_hist[m_e - j];
                        s = h[i];
                    end else begin
                        s = 1'b0;
                    end
                    if (s == m_stable[i]) all_diff = 1'b0;
                end
                if (all_diff) begin
                    if (!m_stable[i]) begin
                        press[i]        = 1'b1;
                        m_press_edge[i] = m_e;
                    end
                    m_stable[i]    = ~m_stable[i];
                    m_last_flip[i] = m_e;
                end
            end
        end
        set   = press | rep;
        ackf  = m_valid && ack;
        ai    = int'(m_code) - 1;
        m_ovr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (set[i] && m_pend[i] && !(ackf && ai == i)) m_ovr = 1'b1;
        end
        found = 0;
        win   = 0;
        if (!m_valid || ackf) begin
            for (int off = 1; off <= 8; off++) begin
                idx = (m_lg + off) % 8;
                if (!found && m_pend[idx] && !(ackf && idx == ai)) begin
                    found = 1;
                    win   = idx;
                end
            end
        end
        if (ackf) m_pend[ai] = 1'b0;
        m_pend = m_pend | set;
        if (!m_valid || ackf) begin
            if (found) begin
                m_valid = 1'b1;
                m_code  = 4'(win + 1);
                m_lg    = win;
            end else begin
                m_valid = 1'b0;
                m_code  = 4'd0;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {18'b0, irq_valid, irq_code, btn_state, irq_overrun};
    endfunction

    // One clock: drive, advance the model with the edge, sample 1 time unit later.
    task automatic cycle(input logic [7:0] r, input logic ack, input logic rs);
        {btn_b, btn_a, btn_start, btn_select, btn_up, btn_down, btn_right, btn_left} = r;
        irq_ack = ack;
        rst     = rs;
        @(posedge clk);
        model_step(r, ack, rs);
        #1;
        check("model", dut_vec(), {18'b0, m_valid, m_code, m_stable, m_ovr});
    endtask

    task automatic do_reset();
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
    endtask

    typedef struct {
        logic [7:0] raw;
        logic       ack;
        logic       v;
        logic [3:0] code;
        logic [7:0] btn;
        logic       ovr;
    } vec_t;

    vec_t       tbl[11];
    int         ev[$];
    int         offs[4];
    logic       seen;
    logic [7:0] rr;
    logic       bval, aval;

    initial begin
        // Left pressed from edge 2: accepted at edge 7, presented at 8, acked at 9.
        tbl[0]  = '{8'h00, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0};
        for (int t = 1; t < 6; t++) tbl[t] = '{8'h01, 1'b0, 1'b0, 4'd0, 8'h00, 1'b0};
        tbl[6]  = '{8'h01, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0};
        tbl[7]  = '{8'h01, 1'b0, 1'b1, 4'd1, 8'h01, 1'b0};
        tbl[8]  = '{8'h01, 1'b1, 1'b0, 4'd0, 8'h01, 1'b0};
        tbl[9]  = '{8'h00, 1'b0, 1'b0, 4'd0, 8'h01, 1'b0};
        tbl[10] = '{8'h00, 1'b1, 1'b0, 4'd0, 8'h01, 1'b0};
        offs    = '{0, 16, 24, 32};
        model_reset();

        do_reset();
        check("reset_state", dut_vec(), 32'h0);
        for (int t = 1; t <= 20; t++) begin
            cycle(8'h00, 1'b0, 1'b0);
            check("idle", dut_vec(), 32'h0);
        end

        do_reset();
        for (int t = 0; t < 11; t++) begin
            cycle(tbl[t].raw, tbl[t].ack, 1'b0);
            check($sformatf("table[%0d]", t), dut_vec(),
                  {18'b0, tbl[t].v, tbl[t].code, tbl[t].btn, tbl[t].ovr});
        end

        // Left and a together, ack held: codes 1 then 7 back to back, then idle.
        do_reset();
        for (int t = 1; t <= 10; t++) begin
            cycle(8'h41, 1'b1, 1'b0);
            if (t == 7) check("rr_first", {irq_valid, irq_code}, {1'b1, 4'd1});
            if (t == 8) check("rr_second", {irq_valid, irq_code}, {1'b1, 4'd7});
            if (t == 9) check("rr_drain", {irq_valid, irq_code}, {1'b0, 4'd0});
        end

        // Two-cycle glitch on down must leave no trace.
        do_reset();
        seen = 1'b0;
        for (int t = 1; t <= 15; t++) begin
            cycle((t <= 2) ? 8'h04 : 8'h00, 1'b0, 1'b0);
            seen = seen | irq_valid | (|btn_state);
        end
        check("glitch", {31'b0, seen}, 32'h0);

        // b re-pressed while pending (overrun), then pressed on the edge of its ack.
        do_reset();
        for (int t = 1; t <= 55; t++) begin
            bval = (t <= 8) || (t >= 15 && t <= 24) || (t >= 31 && t <= 37) || (t >= 44);
            aval = (t == 22) || (t == 49);
            cycle({bval, 7'b0}, aval, 1'b0);
            if (t == 7)  check("b_first", {irq_valid, irq_code}, {1'b1, 4'd8});
            if (t == 20) check("ovr_pulse", {31'b0, irq_overrun}, 32'h1);
            if (t == 21) check("ovr_single", {31'b0, irq_overrun}, 32'h0);
            if (t == 23) check("b_one_event", {irq_valid, irq_code}, {1'b0, 4'd0});
            if (t == 35) check("b_still_idle", {31'b0, irq_valid}, 32'h0);
            if (t == 49) check("ack_set_gap", {irq_valid, irq_overrun}, 2'b00);
            if (t == 50) check("ack_set_new", {irq_valid, irq_code}, {1'b1, 4'd8});
        end

        // Right held (debounced hold just under 40 cycles), every event acked at once.
        do_reset();
        ev.delete();
        for (int t = 1; t <= 60; t++) begin
            cycle((t <= 39) ? 8'h02 : 8'h00, 1'b1, 1'b0);
            if (irq_valid && irq_code == 4'd2) ev.push_back(t);
        end
`ifdef INPUT_AUTOREPEAT_EN
        check("repeat_count", ev.size(), 4);
        for (int k = 1; k < 4; k++) begin
            if (k < ev.size()) check($sformatf("repeat_off[%0d]", k), ev[k] - ev[0], offs[k]);
        end
`else
        check("repeat_count", ev.size(), 1);
`endif

        // Reset with b held discards the event; b re-registers after full latency.
        do_reset();
        for (int t = 1; t <= 8; t++) cycle(8'h80, 1'b0, 1'b0);
        cycle(8'h80, 1'b0, 1'b1);
        cycle(8'h80, 1'b0, 1'b1);
        check("rst_discard", dut_vec(), 32'h0);
        for (int t = 1; t <= 8; t++) begin
            cycle(8'h80, 1'b0, 1'b0);
            if (t == 5) check("rst_held_wait", {irq_valid, btn_state}, 9'h000);
            if (t == 6) check("rst_held_btn", {irq_valid, btn_state}, 9'h080);
            if (t == 7) check("rst_held_evt", {irq_valid, irq_code}, {1'b1, 4'd8});
        end

        // Randomized run: slowly toggling buttons, random acks, rare resets.
        do_reset();
        rr = '0;
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 5) == 0) rr[i] = ~rr[i];
            end
            cycle(rr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
